// File: rtl/seg7_serial_rx.sv
// seg7_serial_rx: oversampling receiver for the 8-digit 7-segment serial chain.
// Deserializes 64-bit frames, latches the raw pattern and decodes each digit
// back to a hex nibble plus decimal point.
module seg7_serial_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seg_clk,
  input  logic                  seg_do,
  input  logic                  seg_pen,
  input  logic                  seg_clr,
  output logic [FRAME_BITS-1:0] seg_pattern,
  output logic [31:0]           digits,
  output logic [7:0]            digit_ok,
  output logic [7:0]            point,
  output logic                  frame_valid,
  output logic                  frame_err
);

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned CNT_W      = 7;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  // Synchronizer chains; bit 0 is the first stage
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] do_sync_q;
  logic [SYNC_STAGES-1:0] pen_sync_q;
  logic [SYNC_STAGES-1:0] clr_sync_q;

  // Edge-detect history
  logic clk_prev_q;
  logic pen_prev_q;

  // Deserializer state
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Frame-end event, carried one cycle to the output stage
  logic                  good_q, good_d;
  logic                  bad_q, bad_d;
  logic [FRAME_BITS-1:0] snap_q, snap_d;

  // Decode of the snapshot, registered into the outputs
  logic [31:0] dec_digits;
  logic [7:0]  dec_ok;
  logic [7:0]  dec_point;

  logic clk_s, do_s, pen_s, clr_s;
  logic clk_rise, pen_rise;

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign do_s     = do_sync_q[SYNC_STAGES-1];
  assign pen_s    = pen_sync_q[SYNC_STAGES-1];
  assign clr_s    = clr_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;
  assign pen_rise = pen_s & ~pen_prev_q;

  // Active-low glyph to {ok, nibble}; anything unrecognized is {0, 0}
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Synchronize serial inputs; reset to idle levels so no edge appears after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q <= {SYNC_STAGES{1'b0}};
      do_sync_q  <= {SYNC_STAGES{1'b0}};
      pen_sync_q <= {SYNC_STAGES{1'b1}};
      clr_sync_q <= {SYNC_STAGES{1'b1}};
      clk_prev_q <= 1'b0;
      pen_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], seg_clk};
      do_sync_q  <= {do_sync_q[SYNC_STAGES-2:0], seg_do};
      pen_sync_q <= {pen_sync_q[SYNC_STAGES-2:0], seg_pen};
      clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], seg_clr};
      clk_prev_q <= clk_s;
      pen_prev_q <= pen_s;
    end
  end

  // Next-state: clear dominates, shift precedes the frame-end count check
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    good_d  = 1'b0;
    bad_d   = 1'b0;
    snap_d  = snap_q;
    if (!clr_s) begin
      shift_d = '1;
      cnt_d   = '0;
    end else if (clk_rise) begin
      shift_d = {shift_q[FRAME_BITS-2:0], do_s};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (pen_rise) begin
      if (cnt_d == CNT_FULL) begin
        good_d = 1'b1;
        snap_d = shift_d;
      end else begin
        bad_d = 1'b1;
      end
      cnt_d = '0;
    end
  end

  // Deserializer and frame-end event registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '1;
      cnt_q   <= '0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
      snap_q  <= '1;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      snap_q  <= snap_d;
    end
  end

  // Per-digit decode of the captured frame
  always_comb begin
    dec_digits = '0;
    dec_ok     = '0;
    dec_point  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      logic [4:0] g;
      g = decode_glyph(snap_q[8*k +: 7]);
      dec_digits[4*k +: 4] = g[3:0];
      dec_ok[k]            = g[4];
      dec_point[k]         = ~snap_q[8*k + 7];
    end
  end

  // Output stage: all latched outputs and frame_valid change on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_pattern <= '1;
      digits      <= '0;
      digit_ok    <= '0;
      point       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= good_q;
      frame_err   <= bad_q;
      if (good_q) begin
        seg_pattern <= snap_q;
        digits      <= dec_digits;
        digit_ok    <= dec_ok;
        point       <= dec_point;
      end
    end
  end

endmodule

// File: doc/seg7_serial_rx.md
# seg7_serial_rx

Receiver for the four-wire serial stream that drives the board's 8-digit 7-segment shift-register chain (SEGLED_CLK / SEGLED_DO / SEGLED_PEN / SEGLED_CLR). It oversamples the stream in the system clock domain and deserializes each 64-bit frame. It latches the raw segment pattern and decodes every digit back to a hex nibble plus decimal point. It sits beside the score display path, so the displayed value can be mirrored onto the VGA overlay and checked in simulation and on-board self-test.

## Interface
- SYNC_STAGES, 2, synchronizer flops per serial input (≥2)
- FRAME_BITS, 64, bits per frame; fixed at 8 × 8 segments

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- seg_clk  in  1  serial shift clock (asynchronous to clk)
- seg_do  in  1  serial data
- seg_pen  in  1  parallel-output enable; rising edge ends a frame
- seg_clr  in  1  active-low chain clear
- seg_pattern  out  64  last good frame; byte k = digit k (k=0 rightmost), bits {dp,g,f,e,d,c,b,a}, active-low
- digits  out  32  decoded nibble per digit, nibble k = digit k
- digit_ok  out  8  bit k = 1 when digit k pattern is a legal hex glyph
- point  out  8  bit k = 1 when dp of digit k is lit
- frame_valid  out  1  one-cycle pulse: new good frame latched
- frame_err  out  1  one-cycle pulse: frame ended with bit count ≠ 64

## Operation
- All four serial inputs pass through SYNC_STAGES flops, then one edge-detect register.
- Rising edge of synchronized seg_clk: shift_reg <= {shift_reg[62:0], seg_do_sync}; bit_cnt increments, saturating at 65. Data is sampled from the same synchronized stage as the clock.
- First bit shifted ends in shift_reg[63].
- Rising edge of synchronized seg_pen:
  - bit_cnt == 64: copy shift_reg to seg_pattern, update digits/digit_ok/point, pulse frame_valid.
  - Otherwise: pulse frame_err; all outputs hold.
  - Either case: bit_cnt <= 0.
- seg_clr_sync low: shift_reg <= all ones and bit_cnt <= 0, every cycle it stays low. Shifts are ignored while low. Latched outputs are not affected.
- seg_clk and seg_pen edges detected in the same cycle: the shift is applied first, then the count check.
- Decode uses bits [6:0] of each byte, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (values with dp bit set to 1).
  - Any other 7-bit value, including blank 7F: nibble 0, digit_ok bit 0.
- point[k] = ~seg_pattern[8k+7].
- Reset values:
  - seg_pattern: all ones.
  - digits: 0.
  - digit_ok: 0.
  - point: 0.
  - frame_valid, frame_err: 0.
  - shift_reg: all ones.
  - bit_cnt: 0.
  - sync/edge registers: idle levels, which are seg_clk 0, seg_pen 1, seg_clr 1. This prevents spurious edges after reset.

## Timing
- Pin edge to internal action: SYNC_STAGES + 1 clk cycles (3 by default).
- Output update: seg_pattern, digits, digit_ok, point and frame_valid all change on the same clk edge, 1 cycle after the internal seg_pen edge. Pin seg_pen rise to frame_valid high is 4 cycles by default.
- frame_valid and frame_err are exactly one cycle wide and never assert together.
- Input constraint: seg_clk high and low phases, and seg_do setup/hold around the seg_clk rise, are each ≥ SYNC_STAGES + 2 clk cycles. A narrower pulse may be missed; the result is then undefined but yields frame_err, never a hang.
- rst_n low mid-frame: partial frame discarded. The next frame must start from bit 0 after rst_n rises.
- No back-pressure; consecutive frames may be separated by any gap ≥ 1 seg_clk period.

## Test plan
- Reset, then send 64 bits encoding "00000123" with no dp, then pulse seg_pen. Required: frame_valid once, digits=0x00000123, digit_ok=0xFF, point=0x00, seg_pattern=0xC0C0C0C0C0F9A4B0.
- Send 63 bits, then seg_pen. Required: frame_err once, no frame_valid, outputs unchanged. Then send a full 64-bit "FFFFFFFF" frame. Required: frame_valid, digits=0xFFFFFFFF.
- Send 70 bits, then seg_pen. Required: frame_err (count saturated at 65), outputs unchanged.
- Send 30 bits, pulse seg_clr low for 5 cycles, then send a full frame with digit 3 = 0x7F and digit 0 = 0x40 ("0" with dp). Required: frame_valid, digit_ok[3]=0, digits nibble 3 = 0, point[0]=1, digits nibble 0 = 0.
- Assert rst_n low for 2 cycles after 40 bits of a frame, then send a full 64-bit frame. Required: all outputs equal reset values during reset; exactly one frame_valid afterwards, with the correct pattern.
- Run back-to-back frames at seg_clk = clk/16 (the board rate), 100 random patterns. Required: every frame yields frame_valid, seg_pattern matches the sent data, and decode matches the table.
